// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor: word width, opcode/function
// encodings and the timestep type consumed by the controller.
package proc_pkg;

  localparam int W = 10;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_SUBI = 2'b11;

  localparam logic [3:0] F_LOAD = 4'b0000;
  localparam logic [3:0] F_COPY = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_SUB  = 4'b0011;
  localparam logic [3:0] F_INV  = 4'b0100;
  localparam logic [3:0] F_FLIP = 4'b0101;
  localparam logic [3:0] F_AND  = 4'b0110;
  localparam logic [3:0] F_OR   = 4'b0111;
  localparam logic [3:0] F_XOR  = 4'b1000;
  localparam logic [3:0] F_LSL  = 4'b1001;
  localparam logic [3:0] F_LSR  = 4'b1010;
  localparam logic [3:0] F_ASR  = 4'b1011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; the head word is visible combinationally so
// the issuer can place it on the bus in the same cycle it pops.
module instr_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: buffers host words, drives DIN at T0 and owns the
// timestep counter, with a watchdog for instructions that never assert Clr.
module instr_issuer #(
  parameter int W     = proc_pkg::W,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             host_data,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic                     run,
  input  logic                     Clr,
  input  logic                     Ext,
  output logic [W-1:0]             DIN,
  output logic                     issue_valid,
  output logic [1:0]               T,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         retired,
  output logic                     illegal,
  output logic                     ext_err
);

  import proc_pkg::*;

  tstep_t           t_q, t_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             ext_err_q, ext_err_d;
  logic [W-1:0]     head;
  logic             full, empty, issue;

  instr_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (host_valid && !full),
    .data_i  (host_data),
    .pop_i   (issue),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  // Clr only counts during execution; a T3 without Clr is the watchdog case.
  always_comb begin
    t_d       = t_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    ext_err_d = ext_err_q | (Ext && (t_q != T0));
    issue     = (t_q == T0) && run && !empty;
    if (t_q == T0) begin
      if (issue) t_d = T1;
    end else if (Clr) begin
      t_d       = T0;
      retired_d = retired_q + CNT_W'(1);
    end else if (t_q == T3) begin
      t_d       = T0;
      illegal_d = 1'b1;
    end else begin
      t_d = tstep_t'(t_q + 2'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q       <= T0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      ext_err_q <= 1'b0;
    end else begin
      t_q       <= t_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      ext_err_q <= ext_err_d;
    end
  end

  assign DIN         = issue ? head : '0;
  assign issue_valid = issue;
  assign T           = t_q;
  assign busy        = (t_q != T0);
  assign host_ready  = !full;
  assign retired     = retired_q;
  assign illegal     = illegal_q;
  assign ext_err     = ext_err_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: stimulus queues expected words with the
// timestep at which the controller model should assert Clr.
module tb_instr_issuer;

  localparam int W     = 10;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [W-1:0]           host_data;
  logic                   host_valid;
  logic                   host_ready;
  logic                   run;
  logic                   Clr;
  logic                   Ext;
  logic [W-1:0]           DIN;
  logic                   issue_valid;
  logic [1:0]             T;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       retired;
  logic                   illegal;
  logic                   ext_err;

  typedef struct {
    logic [W-1:0] word;
    logic [1:0]   clrT;
  } expEntry_t;

  expEntry_t  expQ[$];
  logic [1:0] curClr = 2'd0;
  logic       clrForce = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  // Controller model: Clr at the timestep recorded for the word in flight (0 = never).
  assign Clr = clrForce || ((curClr != 2'd0) && (T == curClr));

  instr_issuer #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .run         (run),
    .Clr         (Clr),
    .Ext         (Ext),
    .DIN         (DIN),
    .issue_valid (issue_valid),
    .T           (T),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .retired     (retired),
    .illegal     (illegal),
    .ext_err     (ext_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] w, input logic [1:0] clrT, input logic expAccept);
    expEntry_t e;
    host_data  = w;
    host_valid = 1'b1;
    checkOutput("host_ready_on_push", host_ready, expAccept);
    if (expAccept) begin
      e.word = w;
      e.clrT = clrT;
      expQ.push_back(e);
    end
    tick();
    host_valid = 1'b0;
    host_data  = '0;
  endtask

  // Monitor: every issue pops the scoreboard; idle cycles must keep DIN at 0.
  always @(negedge clk) begin
    expEntry_t e;
    if (rst) begin
      curClr = 2'd0;
    end else if (issue_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_issue: got DIN 0x%0h expected no issue at %0t", DIN, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("issue_DIN", DIN, e.word);
        curClr = e.clrT;
      end
    end else begin
      checkOutput("idle_DIN", DIN, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst = 1'b1; host_data = '0; host_valid = 1'b0; run = 1'b0; Ext = 1'b0;
    tick(); tick();
    checkOutput("rst_T", T, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_host_ready", host_ready, 1);
    checkOutput("rst_issue_valid", issue_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_retired", retired, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_ext_err", ext_err, 0);
    rst = 1'b0;
    tick();

    // add R1,R2 : four cycles, Clr at T3
    applyStimulus(10'h062, 2'd3, 1'b1);
    checkOutput("t1_stall_iv", issue_valid, 0);
    run = 1'b1; #1;
    checkOutput("t1_T0", T, 0);
    checkOutput("t1_iv0", issue_valid, 1);
    tick(); checkOutput("t1_T1", T, 1); checkOutput("t1_busy", busy, 1);
    checkOutput("t1_iv1", issue_valid, 0);
    tick(); checkOutput("t1_T2", T, 2);
    tick(); checkOutput("t1_T3", T, 3);
    tick(); checkOutput("t1_Tend", T, 0);
    checkOutput("t1_retired", retired, 1);
    checkOutput("t1_illegal", illegal, 0);
    checkOutput("t1_fifo_count", fifo_count, 0);
    run = 1'b0;

    // load then copy, Clr at T1, back-to-back issue
    applyStimulus(10'h040, 2'd1, 1'b1);
    applyStimulus(10'h061, 2'd1, 1'b1);
    checkOutput("t2_fifo_count", fifo_count, 2);
    run = 1'b1; #1;
    checkOutput("t2_iv_a", issue_valid, 1);
    tick(); checkOutput("t2_T1a", T, 1);
    tick(); checkOutput("t2_T0b", T, 0); checkOutput("t2_iv_b", issue_valid, 1);
    tick(); checkOutput("t2_T1b", T, 1);
    tick(); checkOutput("t2_Tend", T, 0); checkOutput("t2_iv_end", issue_valid, 0);
    checkOutput("t2_retired", retired, 3);
    checkOutput("t2_fifo_count_end", fifo_count, 0);
    run = 1'b0;

    // opcode 01 never asserts Clr -> watchdog, then next word issues
    applyStimulus(10'h100, 2'd0, 1'b1);
    applyStimulus(10'h062, 2'd3, 1'b1);
    run = 1'b1; #1;
    checkOutput("t3_iv", issue_valid, 1);
    tick(); checkOutput("t3_T1", T, 1);
    tick(); checkOutput("t3_T2", T, 2);
    tick(); checkOutput("t3_T3", T, 3); checkOutput("t3_illegal_pre", illegal, 0);
    tick(); checkOutput("t3_T0", T, 0);
    checkOutput("t3_illegal", illegal, 1);
    checkOutput("t3_retired_wd", retired, 3);
    checkOutput("t3_iv_next", issue_valid, 1);
    tick(); tick(); tick(); tick();
    checkOutput("t3_Tend", T, 0);
    checkOutput("t3_retired", retired, 4);
    run = 1'b0;

    // fill the FIFO, reject a ninth push, then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(W'(i * 37 + 5), 2'd1, 1'b1);
    checkOutput("t4_full_count", fifo_count, DEPTH);
    checkOutput("t4_host_ready", host_ready, 0);
    applyStimulus(10'h3FF, 2'd1, 1'b0);
    checkOutput("t4_count_after_reject", fifo_count, DEPTH);
    run = 1'b1; #1;
    checkOutput("t4_iv", issue_valid, 1);
    tick();
    checkOutput("t4_ready_after_pop", host_ready, 1);
    checkOutput("t4_count_after_pop", fifo_count, DEPTH - 1);
    begin
      int n = 0;
      while (n < 100 && !(expQ.size() == 0 && T == 2'd0)) begin
        tick();
        n++;
      end
      checkOutput("t4_drain_within_budget", (n < 100), 1);
    end
    checkOutput("t4_retired", retired, 12);
    checkOutput("t4_fifo_count_end", fifo_count, 0);

    // empty FIFO with run: stall, Clr and Ext at T0 have no effect
    for (int i = 0; i < 10; i++) begin
      checkOutput("t5_stall_T", T, 0);
      checkOutput("t5_stall_iv", issue_valid, 0);
      tick();
    end
    clrForce = 1'b1; tick(); clrForce = 1'b0;
    checkOutput("t5_clr_T", T, 0);
    checkOutput("t5_clr_retired", retired, 12);
    Ext = 1'b1; tick(); Ext = 1'b0;
    checkOutput("t5_ext_at_T0", ext_err, 0);

    // Ext while busy, then async reset mid-instruction at T2
    applyStimulus(10'h062, 2'd3, 1'b1);
    checkOutput("t6_iv", issue_valid, 1);
    tick(); checkOutput("t6_T1", T, 1);
    Ext = 1'b1; tick(); Ext = 1'b0;
    checkOutput("t6_T2", T, 2);
    checkOutput("t6_ext_err", ext_err, 1);
    #2 rst = 1'b1; #1;
    checkOutput("t6_rst_T", T, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_fifo_count", fifo_count, 0);
    checkOutput("t6_rst_retired", retired, 0);
    checkOutput("t6_rst_illegal", illegal, 0);
    checkOutput("t6_rst_ext_err", ext_err, 0);
    checkOutput("t6_rst_host_ready", host_ready, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t6_post_rst_iv", issue_valid, 0);
      checkOutput("t6_post_rst_T", T, 0);
    end
    applyStimulus(10'h0AB, 2'd2, 1'b1);
    checkOutput("t6_new_iv", issue_valid, 1);
    tick(); checkOutput("t6_new_T1", T, 1);
    tick(); checkOutput("t6_new_T2", T, 2);
    tick(); checkOutput("t6_new_Tend", T, 0);
    checkOutput("t6_new_retired", retired, 1);
    checkOutput("t6_new_illegal", illegal, 0);
    run = 1'b0;
    tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Source end of the 10-bit instruction interface: buffers instruction words from a host, presents each on the external data bus at timestep 0, and owns the 2-bit timestep counter T that the controller consumes.
- Advances T each cycle and returns it to 0 on the controller's Clr; a watchdog recovers from words that never assert Clr (opcode 01, undefined function codes).
- Sits between host/testbench loader and the controller/IR/external-bus mux in the 10-bit processor.

Parameters:
- W, 10, instruction/data word width
- DEPTH, 8, instruction FIFO entries (power of 2, >=2)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- host_data  in  W  instruction word to enqueue
- host_valid  in  1  host offers host_data
- host_ready  out  1  FIFO can accept (= !full)
- run  in  1  permit issue of new instructions
- Clr  in  1  controller end-of-instruction, clears T
- Ext  in  1  controller bus request (monitor only)
- DIN  out  W  external data bus word, to IR
- issue_valid  out  1  DIN holds a valid instruction this T=0 cycle
- T  out  2  timestep to controller
- busy  out  1  instruction in flight (T != 0)
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- retired  out  CNT_W  instructions completed by Clr
- illegal  out  1  sticky: watchdog fired
- ext_err  out  1  sticky: Ext seen while T != 0

Behaviour:
- Reset (async, any time, including mid-instruction): T=0, FIFO empty, fifo_count=0, retired=0, illegal=0, ext_err=0, DIN=0, issue_valid=0, busy=0, host_ready=1. An in-flight instruction is abandoned.
- Enqueue on clk when host_valid && host_ready. host_ready = (fifo_count != DEPTH); no bypass. A push and pop in the same cycle leave the count unchanged.
- Issue: a cycle is an issue cycle when T==0 && run && FIFO non-empty. DIN = FIFO head (combinational, zero latency from head), issue_valid=1. The head pops at that edge and T<=1.
- Stall: when T==0 and (!run || empty), DIN=0, issue_valid=0, and T holds at 0. Downstream gates IRin with issue_valid.
- Execution, T in {1,2,3}:
  - Clr=1: T<=0 and retired<=retired+1. Wraps modulo 2^CNT_W.
  - Clr=0 and T==3: watchdog. T<=0, illegal<=1, retired unchanged.
  - Otherwise T<=T+1.
- Clr at T==0 is ignored.
- Minimum instruction length is 2 cycles (load/copy: T0,T1). Maximum is 4 cycles (T0..T3).
- The next issue happens in the cycle T returns to 0, so there are no bubbles when the FIFO is non-empty.
- Deasserting run mid-instruction does not stop it; the instruction completes, then the issuer stalls at T=0.
- busy = (T != 0).
- ext_err<=1 if Ext==1 while T != 0. Sticky; cleared only by rst.
- T counter wraps naturally (3->0) only via Clr or watchdog; no other path.

Decomposition:
- Package proc_pkg: W, opcode constants (OP_ALU=2'b00, OP_ADDI=2'b10, OP_SUBI=2'b11), function codes (F_LOAD..F_ASR, 4'b0000..4'b1011), timestep typedef tstep_t (logic [1:0]) with T0..T3 constants. Shared with the controller.
- One sub-module: instr_fifo, a synchronous FIFO with parameters W and DEPTH, push/pop/full/empty/count and async active-high reset. instr_issuer holds the T FSM, watchdog, counters and flags.

Test Plan:
- Push add R1,R2 (0x062), run=1, controller model asserts Clr at T=3 -> T sequence 0,1,2,3,0; DIN=0x062 with issue_valid=1 in the first cycle only; retired=1; illegal=0.
- Push load R1 (0x040) then copy R1,R2 (0x061); Clr at T=1 each -> T=0,1,0,1,0; issue cycles back-to-back with no stall; retired=2; fifo_count returns to 0.
- Push 0x100 (opcode 01), Clr never asserted -> T=0,1,2,3,0; illegal=1; retired=0; the next queued word issues on the following T=0.
- Push 8 words with run=0 -> fifo_count=8, host_ready=0, a 9th push is not accepted. Set run=1 -> the 8 words issue in order and host_ready=1 after the first pop.
- Empty FIFO, run=1 -> T stays 0, issue_valid=0, DIN=0 for 10 cycles. Clr pulsed at T=0 -> no change to T or retired.
- Issue 0x062, assert rst asynchronously mid-cycle at T=2 -> T=0, FIFO empty and all flags/counters 0 immediately. After release, no issue occurs until a new push.
